// File: rtl/mult_pkg.sv
// Shared definitions for the 8x8 sequential multiplier controller: state
// encodings, shift codes and the Moore output decode.
package mult_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b000,
    ST_CLEAR = 3'b001,
    ST_CALC  = 3'b010,
    ST_DONE  = 3'b011,
    ST_ERR   = 3'b100
  } state_e;

  localparam logic [1:0] SH_0 = 2'b00;
  localparam logic [1:0] SH_4 = 2'b01;
  localparam logic [1:0] SH_8 = 2'b10;

  localparam int         STEPS     = 4;
  localparam logic [1:0] LAST_STEP = 2'(STEPS - 1);

  typedef struct packed {
    logic       a_sel;
    logic       b_sel;
    logic [1:0] shift_sel;
    logic       clk_ena;
    logic       sclr_n;
    logic       busy;
    logic       done;
    logic       err;
  } ctrl_t;

  localparam ctrl_t CTRL_RESET = '{
    a_sel:     1'b0,
    b_sel:     1'b0,
    shift_sel: SH_0,
    clk_ena:   1'b0,
    sclr_n:    1'b1,
    busy:      1'b0,
    done:      1'b0,
    err:       1'b0
  };

  // Output decode for a given state and partial-product index.
  function automatic ctrl_t decode(input state_e st, input logic [1:0] step);
    ctrl_t c;
    c = CTRL_RESET;
    case (st)
      ST_CLEAR: begin
        c.clk_ena = 1'b1;
        c.sclr_n  = 1'b0;
        c.busy    = 1'b1;
      end
      ST_CALC: begin
        c.clk_ena = 1'b1;
        c.busy    = 1'b1;
        c.a_sel   = step[1];
        c.b_sel   = step[0];
        case (step)
          2'd0:       c.shift_sel = SH_0;
          2'd1, 2'd2: c.shift_sel = SH_4;
          default:    c.shift_sel = SH_8;
        endcase
      end
      ST_DONE: c.done = 1'b1;
      ST_ERR:  c.err  = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mult_ctrl_counter2.sv
// Two-bit step counter with asynchronous reset, synchronous clear and enable.
module counter2 (
  input  logic       clk,
  input  logic       aclr_n,
  input  logic       sclr,
  input  logic       en,
  output logic [1:0] cnt
);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n)  cnt <= '0;
    else if (sclr) cnt <= '0;
    else if (en)   cnt <= cnt + 2'd1;
  end

endmodule

// File: rtl/mult_ctrl.sv
// Control FSM for the 8x8 sequential multiplier (four 4x4 partial products).
// Optional start-while-busy error state enabled by defining MULT_CTRL_ERR_EN.
module mult_ctrl
  import mult_pkg::*;
#(
  parameter bit DONE_PULSE = 1'b0
) (
  input  logic       clk,
  input  logic       aclr_n,
  input  logic       start,
  output logic       a_sel,
  output logic       b_sel,
  output logic [1:0] shift_sel,
  output logic       clk_ena,
  output logic       sclr_n,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [2:0] state_out,
  output logic [1:0] step_cnt
);

  state_e     state_q, state_d;
  logic [1:0] step_d;
  logic       cnt_clr, cnt_en;
  ctrl_t      ctrl_q;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_CLEAR;
      ST_CLEAR: begin
        state_d = ST_CALC;
`ifdef MULT_CTRL_ERR_EN
        if (start) state_d = ST_ERR;
`endif
      end
      ST_CALC: begin
        if (step_cnt == LAST_STEP) state_d = ST_DONE;
`ifdef MULT_CTRL_ERR_EN
        if (start) state_d = ST_ERR;
`endif
      end
      ST_DONE: begin
        if (start)           state_d = ST_CLEAR;
        else if (DONE_PULSE) state_d = ST_IDLE;
      end
      ST_ERR: begin
`ifdef MULT_CTRL_ERR_EN
        if (!start) state_d = ST_IDLE;
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The step index only advances inside CALC and reads 0 everywhere else.
  assign cnt_en  = (state_q == ST_CALC);
  assign cnt_clr = (state_d != ST_CALC);

  always_comb begin
    if (cnt_clr)     step_d = '0;
    else if (cnt_en) step_d = step_cnt + 2'd1;
    else             step_d = step_cnt;
  end

  counter2 u_step (
    .clk    (clk),
    .aclr_n (aclr_n),
    .sclr   (cnt_clr),
    .en     (cnt_en),
    .cnt    (step_cnt)
  );

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q <= ST_IDLE;
      ctrl_q  <= CTRL_RESET;
    end else begin
      state_q <= state_d;
      ctrl_q  <= decode(state_d, step_d);
`ifndef MULT_CTRL_ERR_EN
      ctrl_q.err <= 1'b0;
`endif
    end
  end

  assign a_sel     = ctrl_q.a_sel;
  assign b_sel     = ctrl_q.b_sel;
  assign shift_sel = ctrl_q.shift_sel;
  assign clk_ena   = ctrl_q.clk_ena;
  assign sclr_n    = ctrl_q.sclr_n;
  assign busy      = ctrl_q.busy;
  assign done      = ctrl_q.done;
  assign err       = ctrl_q.err;
  assign state_out = state_q;

endmodule
